// File: rtl/serial_word_assembler.sv
// serial_word_assembler: MSB-first serial-to-parallel word assembler with a one-cycle LOAD strobe.
// Optional even-parity bit and ERR flag are enabled by defining SERIAL_WORD_PARITY_EN.
module serial_word_assembler #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         START,
  input  logic         SIN,
  input  logic         SVALID,
  output logic [N-1:0] WORD,
  output logic         LOAD,
  output logic         BUSY,
  output logic         ERR
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] last_idx = CW'(N - 1);
`ifdef SERIAL_WORD_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0] shreg, shifted;
  logic last_bit;
  assign shifted = {shreg[N-2:0], SIN};
  assign last_bit = SVALID && cnt == last_idx;
  assign LOAD = st == DONE;
`ifdef SERIAL_WORD_PARITY_EN
  assign BUSY = st == SHIFT || st == PARITY;
`else
  assign BUSY = st == SHIFT;
  assign ERR = 1'b0;
`endif
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:   nxt = START ? SHIFT : IDLE;
`ifdef SERIAL_WORD_PARITY_EN
      SHIFT:  nxt = last_bit ? PARITY : SHIFT;
      PARITY: nxt = SVALID ? DONE : PARITY;
`else
      SHIFT:  nxt = last_bit ? DONE : SHIFT;
`endif
      DONE:   nxt = START ? SHIFT : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      st <= IDLE;
      cnt <= '0;
      shreg <= '0;
      WORD <= '0;
`ifdef SERIAL_WORD_PARITY_EN
      ERR <= 1'b0;
`endif
    end else begin
      st <= nxt;
      if (nxt == SHIFT && st != SHIFT) cnt <= '0;
      else if (st == SHIFT && SVALID) begin
        shreg <= shifted;
        cnt <= cnt + 1'b1;
      end
`ifdef SERIAL_WORD_PARITY_EN
      // parity bit completes the frame; WORD loads even when the check fails
      if (st == PARITY && SVALID) begin
        WORD <= shreg;
        ERR <= ^{shreg, SIN};
      end
`else
      if (st == SHIFT && last_bit) WORD <= shifted;
`endif
    end
  end
endmodule
